axis_stream_checker: RTL



---
 rtl/axis_stream_checker_pkg.sv | 12 +
 rtl/axis_sync_fifo.sv | 47 ++++
 rtl/axis_stream_checker.sv | 122 ++++++++++++
 3 files changed

// File: rtl/axis_stream_checker_pkg.sv
// Shared constants for the stream checker: error-cause bit positions and FSM encoding.
package axis_stream_checker_pkg;

  localparam int unsigned ERR_DATA  = 0;
  localparam int unsigned ERR_EARLY = 1;
  localparam int unsigned ERR_MISS  = 2;
  localparam int unsigned ERR_STRB  = 3;

  localparam logic [0:0] RECV   = 1'b0;
  localparam logic [0:0] RESYNC = 1'b1;

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock show-ahead FIFO; head reads as zero while empty.
module axis_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (!do_push && do_pop) count <= count - (AW+1)'(1);
    end
  end

  // Storage needs no reset: rdata is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/axis_stream_checker.sv
// AXI4-Stream sink that checks the 1..PKT_WORDS generator pattern, buffers beats and counts packets.
module axis_stream_checker
  import axis_stream_checker_pkg::*;
#(
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned PKT_WORDS            = 8,
  parameter int unsigned FIFO_DEPTH           = 8,
  parameter int unsigned CNT_WIDTH            = 16
) (
  input  logic                                S_AXIS_ACLK,
  input  logic                                S_AXIS_ARESET,
  input  logic                                S_AXIS_TVALID,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [(C_S_AXIS_TDATA_WIDTH/8)-1:0] S_AXIS_TSTRB,
  input  logic                                S_AXIS_TLAST,
  output logic                                S_AXIS_TREADY,
  input  logic                                rd_en,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]     rd_data,
  output logic                                rd_valid,
  output logic [CNT_WIDTH-1:0]                pkt_count,
  output logic [CNT_WIDTH-1:0]                err_count,
  output logic [3:0]                          err_cause,
  input  logic                                err_clear
);

  localparam int unsigned DW = C_S_AXIS_TDATA_WIDTH;
  localparam int unsigned IW = $clog2(PKT_WORDS);

  logic                 full, empty, accept, at_last;
  logic [DW-1:0]        exp_data;
  logic [0:0]           state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 pkt_err_q, pkt_err_d;
  logic                 pkt_inc, err_inc;
  logic [3:0]           beat_err, err_cause_d;
  logic [CNT_WIDTH-1:0] pkt_count_q, err_count_q;

  assign S_AXIS_TREADY = !full;
  assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;
  assign rd_valid      = !empty;
  assign pkt_count     = pkt_count_q;
  assign err_count     = err_count_q;
  assign exp_data      = DW'(idx_q) + DW'(1);
  assign at_last       = (idx_q == IW'(PKT_WORDS - 1));

  axis_sync_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (S_AXIS_ACLK),
    .rst   (S_AXIS_ARESET),
    .push  (accept),
    .pop   (rd_en),
    .wdata (S_AXIS_TDATA),
    .rdata (rd_data),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    beat_err = '0;
    if (accept && state_q == RECV) begin
      beat_err[ERR_DATA]  = (S_AXIS_TDATA != exp_data);
      beat_err[ERR_STRB]  = (S_AXIS_TSTRB != '1);
      beat_err[ERR_EARLY] = S_AXIS_TLAST && !at_last;
      beat_err[ERR_MISS]  = !S_AXIS_TLAST && at_last;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pkt_err_d = pkt_err_q;
    pkt_inc   = 1'b0;
    err_inc   = 1'b0;
    if (accept) begin
      if (state_q == RECV) begin
        if (S_AXIS_TLAST) begin
          idx_d     = '0;
          pkt_err_d = 1'b0;
          if (pkt_err_q || (|beat_err)) err_inc = 1'b1;
          else                          pkt_inc = 1'b1;
        end else if (at_last) begin
          // Overrun of the expected length: count it now, then skip to the next TLAST.
          err_inc   = 1'b1;
          state_d   = RESYNC;
          idx_d     = '0;
          pkt_err_d = 1'b0;
        end else begin
          idx_d     = idx_q + IW'(1);
          pkt_err_d = pkt_err_q | (|beat_err);
        end
      end else if (S_AXIS_TLAST) begin
        state_d   = RECV;
        idx_d     = '0;
        pkt_err_d = 1'b0;
      end
    end
  end

  // New errors override a simultaneous clear.
  assign err_cause_d = (err_clear ? 4'b0 : err_cause) | beat_err;

  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      state_q     <= RECV;
      idx_q       <= '0;
      pkt_err_q   <= 1'b0;
      pkt_count_q <= '0;
      err_count_q <= '0;
      err_cause   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pkt_err_q <= pkt_err_d;
      err_cause <= err_cause_d;
      if (pkt_inc && pkt_count_q != '1) pkt_count_q <= pkt_count_q + CNT_WIDTH'(1);
      if (err_inc && err_count_q != '1) err_count_q <= err_count_q + CNT_WIDTH'(1);
    end
  end

endmodule
